// File: rtl/result_vote_window.sv
// result_vote_window: sliding-window majority vote over classification results,
// plus a frame-start to result cycle counter for the debug/7-segment path.
module result_vote_window #(
    parameter int CLASS_W      = 2,
    parameter int WINDOW       = 3,
    parameter int CNT_W        = 32,
    parameter bit HOLD_NO_MAJ  = 1'b1,
    parameter bit EMIT_PARTIAL = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         frame_start,
    input  logic                         result_valid,
    input  logic [CLASS_W-1:0]           result_in,
    output logic                         result_ready,
    output logic [CLASS_W-1:0]           vote_out,
    output logic                         vote_valid,
    output logic                         vote_confident,
    output logic [$clog2(WINDOW+1)-1:0]  fill_count,
    output logic                         overrun,
    output logic [CNT_W-1:0]             cycles_last,
    output logic                         cycles_valid
);

    localparam int NUM_CLASSES = 2 ** CLASS_W;
    localparam int FILL_W      = $clog2(WINDOW + 1);
    localparam int PTR_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [FILL_W-1:0]  FILL_ONE  = 1;
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(WINDOW);
    localparam logic [PTR_W-1:0]   PTR_ONE   = 1;
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(WINDOW - 1);
    localparam logic [CLASS_W-1:0] IDX_ONE   = 1;
    localparam logic [CLASS_W-1:0] IDX_LAST  = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;

    typedef enum logic [1:0] {IDLE, UPDATE, SCAN, EMIT} state_t;

    state_t             state;
    logic [CLASS_W-1:0] buf_mem  [WINDOW];
    logic [FILL_W-1:0]  hist     [NUM_CLASSES];
    logic [FILL_W-1:0]  hist_nxt [NUM_CLASSES];
    logic [PTR_W-1:0]   wr_ptr;
    logic [CLASS_W-1:0] new_cls;
    logic [CLASS_W-1:0] idx;
    logic [CLASS_W-1:0] best;
    logic [FILL_W-1:0]  best_cnt;
    logic [CLASS_W-1:0] evicted;
    logic               full;
    logic               confident;
    logic               accept;
    logic [CNT_W-1:0]   cnt;
    logic               running;

    assign evicted   = buf_mem[wr_ptr];
    assign full      = (fill_count == FILL_FULL);
    assign confident = ({best_cnt, 1'b0} > {1'b0, fill_count});
    assign accept    = (state == IDLE) && result_valid && !clear;

    // Histogram after adding the captured result and evicting the oldest one when full.
    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            // NOTE: every path assigns hist_nxt first, so no latch can be inferred.
            hist_nxt[c] = hist[c];
            if (new_cls == CLASS_W'(c))
                hist_nxt[c] = hist_nxt[c] + FILL_ONE;
            if (full && evicted == CLASS_W'(c))
                hist_nxt[c] = hist_nxt[c] - FILL_ONE;
        end
    end

    // Vote FSM: capture, update window/histogram, scan for the argmax, emit.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            // NOTE: the window buffer is a small flop array, cleared so a restarted
            // window never carries entries from before the flush.
            for (int w = 0; w < WINDOW; w++) buf_mem[w] <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) hist[c] <= '0;
            state          <= IDLE;
            result_ready   <= 1'b1;
            wr_ptr         <= '0;
            fill_count     <= '0;
            new_cls        <= '0;
            idx            <= '0;
            best           <= '0;
            best_cnt       <= '0;
            vote_out       <= '0;
            vote_valid     <= 1'b0;
            vote_confident <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block reading the pre-edge values, whatever the statement order.
            vote_valid <= 1'b0;
            if (result_valid && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (result_valid) begin
                        new_cls      <= result_in;
                        result_ready <= 1'b0;
                        state        <= UPDATE;
                    end
                end
                UPDATE: begin
                    for (int c = 0; c < NUM_CLASSES; c++) hist[c] <= hist_nxt[c];
                    if (!full)
                        fill_count <= fill_count + FILL_ONE;
                    buf_mem[wr_ptr] <= new_cls;
                    wr_ptr   <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
                    best     <= '0;
                    best_cnt <= hist_nxt[0];
                    idx      <= IDX_ONE;
                    state    <= SCAN;
                end
                SCAN: begin
                    // Strict compare: ties keep the lower class index.
                    if (hist[idx] > best_cnt) begin
                        best     <= idx;
                        best_cnt <= hist[idx];
                    end
                    if (idx == IDX_LAST)
                        state <= EMIT;
                    else
                        idx <= idx + IDX_ONE;
                end
                EMIT: begin
                    if (EMIT_PARTIAL || full) begin
                        vote_valid     <= 1'b1;
                        vote_confident <= confident;
                        if (!HOLD_NO_MAJ || confident)
                            vote_out <= best;
                    end
                    result_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    result_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Frame-to-result cycle counter; latches on acceptance before any restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            running      <= 1'b0;
            cycles_last  <= '0;
            cycles_valid <= 1'b0;
        end else begin
            cycles_valid <= 1'b0;
            if (running && cnt != '1)
                cnt <= cnt + CNT_ONE;
            if (accept && running) begin
                cycles_last  <= (cnt == '1) ? cnt : cnt + CNT_ONE;
                cycles_valid <= 1'b1;
                running      <= 1'b0;
            end
            if (frame_start) begin
                cnt     <= '0;
                running <= 1'b1;
            end
        end
    end

endmodule

// File: doc/result_vote_window.md
Name: result_vote_window

Overview:
- Parametrised successor to the fixed 3-sample, 2-bit result voting and frame-cycle counting in the camera/neuroset top level.
- Accepts one classification result per neuroset run (the STOP pulse with RESULT).
- Keeps a sliding window of the last WINDOW results and emits a majority vote with a confidence flag.
- Measures cycles from frame start to result for the 7-segment/debug path.

Parameters:
- CLASS_W, 2: width of a class index; NUM_CLASSES = 2**CLASS_W.
- WINDOW, 3: number of results in the sliding window (≥1).
- CNT_W, 32: width of the frame-cycle counter.
- HOLD_NO_MAJ, 1: 1 = keep previous vote_out when no strict majority; 0 = always output the argmax.
- EMIT_PARTIAL, 0: 1 = vote while the window is still filling; 0 = vote only once fill_count==WINDOW.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous flush of the window, histogram, vote and overrun.
- frame_start  in  1  one-cycle pulse at start of a neuroset run.
- result_valid  in  1  one-cycle pulse (STOP) qualifying result_in.
- result_in  in  CLASS_W  class index.
- result_ready  out  1  high only in IDLE.
- vote_out  out  CLASS_W  voted class.
- vote_valid  out  1  one-cycle pulse when vote_out/vote_confident are updated.
- vote_confident  out  1  winning count*2 > fill_count.
- fill_count  out  $clog2(WINDOW+1)  entries held, saturates at WINDOW.
- overrun  out  1  sticky: a result was dropped while busy.
- cycles_last  out  CNT_W  latched frame-to-result cycle count.
- cycles_valid  out  1  one-cycle pulse when cycles_last is updated.

Behaviour:
- Reset (rst_n low at an edge):
  - All outputs go to 0, except result_ready=1.
  - Buffer pointer, histogram and cycle counter are cleared; FSM goes to IDLE.
  - Reset overrides everything, including mid-operation.
- Storage:
  - Circular buffer of WINDOW × CLASS_W entries; write pointer wraps WINDOW-1 → 0.
  - One histogram counter per class, width $clog2(WINDOW+1).
- FSM states: IDLE, UPDATE, SCAN, EMIT.
  - IDLE: result_valid accepted (captured) → UPDATE.
  - UPDATE (1 cycle):
    - hist[new]++.
    - If fill_count==WINDOW: hist[evicted]-- using the entry at the write pointer before overwrite; if new==evicted the net change is 0.
    - Otherwise fill_count++.
    - Write the buffer, advance the pointer. → SCAN with idx=0, best=0, bestcnt=hist[0].
  - SCAN (NUM_CLASSES-1 cycles, idx 1..NUM_CLASSES-1):
    - If hist[idx] > bestcnt, update best/bestcnt.
    - Strict compare, so ties resolve to the lowest class index. → EMIT after the last idx.
  - EMIT (1 cycle):
    - confident = (bestcnt*2 > fill_count).
    - If EMIT_PARTIAL==0 and fill_count<WINDOW: no vote_valid, outputs unchanged.
    - Otherwise vote_valid=1 and vote_confident=confident.
    - vote_out = best, unless HOLD_NO_MAJ==1 and !confident, in which case vote_out keeps its value.
    - → IDLE.
- Latency: accepted at edge E0; vote_valid is high in the cycle after edge E0+NUM_CLASSES+1, for exactly one cycle.
- Handshake: result_valid while result_ready==0 is dropped and sets overrun (sticky until clear or reset). Buffer and histogram are unchanged.
- clear:
  - Takes effect at the next edge from any state: FSM → IDLE, buffer, histogram, fill_count, vote_out, vote_confident and overrun → 0.
  - No vote_valid is generated for an aborted scan.
  - A result_valid in the same cycle as clear is ignored.
  - The cycle counter is unaffected.
- Cycle counter:
  - frame_start loads 0 and sets running.
  - While running, increments each cycle, saturating at all-ones.
  - On an accepted result while running: cycles_last = counter+1, cycles_valid pulses, running clears.
  - frame_start while running restarts the count.
  - frame_start in the same cycle as acceptance: latch first, then restart.
  - An accepted result while not running: no latch.
- Width rules: all histogram arithmetic is unsigned and never underflows (decrement only for an entry present in the buffer).

Test Plan:
- WINDOW=3, EMIT_PARTIAL=0, HOLD_NO_MAJ=1: push 1,1,2.
  - No vote_valid after the first two.
  - After the third: vote_out=1, vote_confident=1, fill_count=3.
  - vote_valid exactly 6 cycles after acceptance (NUM_CLASSES=4).
- Continue with 3 (window {1,2,3}): vote_valid=1, vote_confident=0, vote_out stays 1. Then push 2 (window {2,3,2}): vote_out=2, confident=1. Repeat with HOLD_NO_MAJ=0: the tie gives vote_out=1 (lowest index).
- Pulse result_valid=3 during SCAN: dropped, overrun=1, fill_count unchanged, no extra vote. Then clear: overrun=0, fill_count=0, vote_out=0.
- frame_start at cycle 0, result accepted at cycle 1000: cycles_last=1000, cycles_valid one cycle. frame_start and result in the same cycle: cycles_last latched, counter restarts at 0.
- Assert rst_n=0 during SCAN: next edge all outputs at reset values, result_ready=1, no vote_valid. Then push 0,0,0: vote_out=0, confident=1.
- WINDOW=5, CLASS_W=3, EMIT_PARTIAL=1: push 7 → vote_out=7, confident=1, fill_count=1. Push 8 results to check pointer wrap and eviction: histogram sum always equals fill_count=5.
